// File: rtl/time_set_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | time_set_controller                                                   |
// | Front-panel time-set sequencer: mode FSM, hold-to-repeat increments,  |
// | digit blink blanking and idle timeout back to RUN.                    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module time_set_controller #(
  parameter int HOLD_MS    = 500,
  parameter int REPEAT_MS  = 100,
  parameter int BLINK_MS   = 250,
  parameter int TIMEOUT_MS = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1khz,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic       run_en,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       blank_hours,
  output logic       blank_mins,
  output logic [1:0] mode
);

  localparam logic [15:0] c_HOLD    = 16'(HOLD_MS);
  localparam logic [15:0] c_REPEAT  = 16'(REPEAT_MS);
  localparam logic [15:0] c_BLINK   = 16'(BLINK_MS);
  localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_MS);

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_SET_HOUR = 2'b01,
    S_SET_MIN  = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_run_en;
  logic        r_inc_min;
  logic        r_inc_hour;
  logic        r_mode_prev;
  logic        r_up_prev;
  logic        r_up_armed;
  logic        r_repeating;
  logic        r_phase;
  logic [15:0] r_hold_cnt;
  logic [15:0] r_blink_cnt;
  logic [15:0] r_idle_cnt;

  logic        w_mode_press;
  logic        w_up_press;
  logic        w_set;
  logic        w_holding;
  logic        w_hold_fire;
  logic        w_timeout;
  logic        w_pulse;
  logic        w_change;
  logic [15:0] w_hold_next;
  logic [15:0] w_blink_next;
  logic [15:0] w_idle_next;

  assign w_mode_press = btn_mode & ~r_mode_prev;
  assign w_up_press   = btn_up & ~r_up_prev;
  assign w_set        = (r_state == S_SET_HOUR) || (r_state == S_SET_MIN);
  assign w_hold_next  = r_hold_cnt + 16'd1;
  assign w_blink_next = r_blink_cnt + 16'd1;
  assign w_idle_next  = r_idle_cnt + 16'd1;

  // A mode press always takes priority over anything the up button does.
  assign w_holding   = w_set & btn_up & r_up_armed & ~w_mode_press;
  assign w_hold_fire = w_holding & tick_1khz &
                       (w_hold_next == (r_repeating ? c_REPEAT : c_HOLD));
  assign w_timeout   = w_set & tick_1khz & ~btn_up & ~w_mode_press &
                       (w_idle_next == c_TIMEOUT);
  assign w_pulse     = w_set & ~w_mode_press & r_up_armed & (w_up_press | w_hold_fire);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN:      if (w_mode_press) w_next = S_SET_HOUR;
      S_SET_HOUR: if (w_mode_press) w_next = S_SET_MIN;
                  else if (w_timeout) w_next = S_RUN;
      S_SET_MIN:  if (w_mode_press || w_timeout) w_next = S_RUN;
      default:    w_next = S_RUN;
    endcase
  end

  assign w_change = (w_next != r_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_run_en    <= 1'b1;
      r_inc_min   <= 1'b0;
      r_inc_hour  <= 1'b0;
      r_mode_prev <= 1'b1;
      r_up_prev   <= 1'b1;
      r_up_armed  <= 1'b1;
      r_repeating <= 1'b0;
      r_phase     <= 1'b0;
      r_hold_cnt  <= 16'd0;
      r_blink_cnt <= 16'd0;
      r_idle_cnt  <= 16'd0;
    end else begin
      r_mode_prev <= btn_mode;
      r_up_prev   <= btn_up;
      r_state     <= w_next;
      r_run_en    <= (w_next == S_RUN);
      r_inc_hour  <= w_pulse & (r_state == S_SET_HOUR);
      r_inc_min   <= w_pulse & (r_state == S_SET_MIN);

      // A button still held across a state change stays disarmed until released.
      if (w_change) r_up_armed <= ~btn_up;
      else if (!btn_up) r_up_armed <= 1'b1;

      if (!w_holding || w_change) begin
        r_hold_cnt  <= 16'd0;
        r_repeating <= 1'b0;
      end else if (tick_1khz) begin
        if (w_hold_fire) begin
          r_hold_cnt  <= 16'd0;
          r_repeating <= 1'b1;
        end else begin
          r_hold_cnt <= w_hold_next;
        end
      end

      if (w_change || !w_set) begin
        r_blink_cnt <= 16'd0;
        r_phase     <= 1'b0;
      end else if (tick_1khz) begin
        if (w_blink_next == c_BLINK) begin
          r_blink_cnt <= 16'd0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= w_blink_next;
        end
      end

      if (w_change || !w_set || btn_up) r_idle_cnt <= 16'd0;
      else if (tick_1khz) r_idle_cnt <= (w_idle_next == c_TIMEOUT) ? 16'd0 : w_idle_next;
    end
  end

  assign run_en      = r_run_en;
  assign inc_min     = r_inc_min;
  assign inc_hour    = r_inc_hour;
  assign mode        = r_state;
  assign blank_hours = (r_state == S_SET_HOUR) & r_phase & ~btn_up;
  assign blank_mins  = (r_state == S_SET_MIN) & r_phase & ~btn_up;

endmodule
`default_nettype wire

// File: tb/tb_time_set_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_time_set_controller                                                |
// | Directed stimulus with a per-cycle reference model and literal checks.|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_time_set_controller;

  localparam int HOLD    = 500;
  localparam int REPEAT  = 100;
  localparam int BLINK   = 250;
  localparam int TIMEOUT = 10000;

  logic       clk = 1'b0;
  logic       rst, tick_1khz, btn_mode, btn_up;
  logic       run_en, inc_min, inc_hour, blank_hours, blank_mins;
  logic [1:0] mode;

  int checks   = 0;
  int failures = 0;
  int cnt_min  = 0;
  int cnt_hour = 0;

  time_set_controller #(
    .HOLD_MS(HOLD), .REPEAT_MS(REPEAT), .BLINK_MS(BLINK), .TIMEOUT_MS(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .tick_1khz(tick_1khz), .btn_mode(btn_mode), .btn_up(btn_up),
    .run_en(run_en), .inc_min(inc_min), .inc_hour(inc_hour),
    .blank_hours(blank_hours), .blank_mins(blank_mins), .mode(mode)
  );

  always #5 clk = ~clk;

  // Reference model: tracks elapsed tick counts and derives outputs arithmetically.
  int m_mode = 0;
  bit m_inc_min = 0, m_inc_hour = 0;
  bit m_mode_prev = 1, m_up_prev = 1, m_armed = 1, m_valid = 0;
  int m_held = 0, m_state_ticks = 0, m_idle = 0;

  always @(posedge clk) begin
    bit mp, up, set, fire, pulse, tmo, phase;
    int nmode;
    if (rst) begin
      m_mode = 0; m_inc_min = 0; m_inc_hour = 0;
      m_mode_prev = 1; m_up_prev = 1; m_armed = 1;
      m_held = 0; m_state_ticks = 0; m_idle = 0;
      m_valid = 1;
    end else begin
      mp  = btn_mode && !m_mode_prev;
      up  = btn_up && !m_up_prev;
      set = (m_mode != 0);
      fire = 0;
      if (!set || !btn_up || !m_armed || mp) m_held = 0;
      else if (tick_1khz) begin
        m_held++;
        fire = (m_held == HOLD) || (m_held > HOLD && ((m_held - HOLD) % REPEAT) == 0);
      end
      pulse = set && !mp && m_armed && (up || fire);
      m_inc_hour = pulse && (m_mode == 1);
      m_inc_min  = pulse && (m_mode == 2);
      tmo = 0;
      if (set) begin
        if (mp || btn_up) m_idle = 0;
        else if (tick_1khz) begin
          m_idle++;
          tmo = (m_idle == TIMEOUT);
        end
        if (tick_1khz) m_state_ticks++;
      end
      nmode = m_mode;
      if (mp) nmode = (m_mode + 1) % 3;
      else if (tmo) nmode = 0;
      if (nmode != m_mode) begin
        m_mode = nmode; m_state_ticks = 0; m_idle = 0; m_held = 0;
        m_armed = !btn_up;
      end else if (!btn_up) m_armed = 1;
      m_mode_prev = btn_mode;
      m_up_prev   = btn_up;
    end
    #1;
    if (m_valid) begin
      phase = ((m_state_ticks / BLINK) % 2) == 1;
      checks++;
      if (mode !== 2'(m_mode) || run_en !== (m_mode == 0) || inc_min !== m_inc_min ||
          inc_hour !== m_inc_hour ||
          blank_hours !== ((m_mode == 1) && phase && !btn_up) ||
          blank_mins !== ((m_mode == 2) && phase && !btn_up)) begin
        failures++;
        $display("FAIL cycle t=%0t got mode=%0d run=%0b im=%0b ih=%0b bh=%0b bm=%0b want mode=%0d run=%0b im=%0b ih=%0b bh=%0b bm=%0b",
                 $time, mode, run_en, inc_min, inc_hour, blank_hours, blank_mins,
                 m_mode, (m_mode == 0), m_inc_min, m_inc_hour,
                 ((m_mode == 1) && phase && !btn_up), ((m_mode == 2) && phase && !btn_up));
      end
      if (inc_min) cnt_min++;
      if (inc_hour) cnt_hour++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic t);
    @(negedge clk);
    tick_1khz = t;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step(1'b1);
      step(1'b0);
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step(1'b0);
    btn_mode = 1'b0;
    step(1'b0);
  endtask

  initial begin
    rst = 1'b1; tick_1khz = 1'b0; btn_mode = 1'b0; btn_up = 1'b0;
    repeat (3) step(1'b0);
    rst = 1'b0;
    step(1'b0);
    chk("reset_mode", int'(mode), 0);
    chk("reset_run_en", int'(run_en), 1);
    chk("reset_inc", int'(inc_min) + int'(inc_hour), 0);

    // Up button is ignored in RUN
    cnt_min = 0; cnt_hour = 0;
    btn_up = 1'b1;
    ticks(10);
    btn_up = 1'b0;
    step(1'b0);
    chk("run_up_ignored", cnt_min + cnt_hour, 0);

    press_mode();
    chk("mode_seq1", int'(mode), 1);
    chk("run_en_seq1", int'(run_en), 0);
    press_mode();
    chk("mode_seq2", int'(mode), 2);
    chk("run_en_seq2", int'(run_en), 0);
    press_mode();
    chk("mode_seq3", int'(mode), 0);
    chk("run_en_seq3", int'(run_en), 1);

    // Mode held through reset must not count as a press
    btn_mode = 1'b1; rst = 1'b1;
    step(1'b0); step(1'b0);
    rst = 1'b0;
    repeat (4) step(1'b0);
    chk("mode_held_rst", int'(mode), 0);
    btn_mode = 1'b0;
    step(1'b0);
    press_mode();
    chk("mode_after_repress", int'(mode), 1);
    press_mode();
    chk("mode_set_min", int'(mode), 2);

    // Hold-to-repeat in SET_MIN
    cnt_min = 0; cnt_hour = 0;
    btn_up = 1'b1;
    step(1'b0);
    chk("press_pulse", int'(inc_min), 1);
    step(1'b0);
    chk("press_pulse_width", int'(inc_min), 0);
    ticks(HOLD - 1);
    chk("hold_before_500", cnt_min, 1);
    ticks(1);
    chk("hold_at_500", cnt_min, 2);
    ticks(300);
    chk("hold_total", cnt_min, 5);
    chk("hold_no_hour", cnt_hour, 0);
    btn_up = 1'b0;
    step(1'b0);

    // Blink and timeout in SET_HOUR
    press_mode();
    press_mode();
    chk("mode_set_hour", int'(mode), 1);
    ticks(BLINK - 1);
    chk("blink_visible", int'(blank_hours), 0);
    ticks(1);
    chk("blink_blank", int'(blank_hours), 1);
    chk("blink_mins_off", int'(blank_mins), 0);
    ticks(BLINK);
    chk("blink_visible2", int'(blank_hours), 0);
    ticks(BLINK);
    chk("blink_blank2", int'(blank_hours), 1);
    btn_up = 1'b1;
    #1;
    chk("blank_up_override", int'(blank_hours), 0);
    step(1'b0);
    chk("hour_pulse", int'(inc_hour), 1);
    step(1'b0);
    btn_up = 1'b0;
    step(1'b0);
    ticks(TIMEOUT - 1);
    chk("timeout_not_yet", int'(mode), 1);
    ticks(1);
    chk("timeout_mode", int'(mode), 0);
    chk("timeout_run_en", int'(run_en), 1);

    // Same-cycle mode + up: mode wins, held up stays disarmed
    press_mode();
    cnt_min = 0; cnt_hour = 0;
    btn_mode = 1'b1; btn_up = 1'b1;
    step(1'b0);
    btn_mode = 1'b0;
    chk("simul_mode", int'(mode), 2);
    ticks(600);
    chk("simul_no_pulse", cnt_min + cnt_hour, 0);
    btn_up = 1'b0;
    step(1'b0);
    btn_up = 1'b1;
    step(1'b0);
    chk("repress_pulse", int'(inc_min), 1);
    btn_up = 1'b0;
    step(1'b0);

    // Reset arriving on the 600th held tick
    cnt_min = 0; cnt_hour = 0;
    btn_up = 1'b1;
    step(1'b0);
    ticks(599);
    chk("pre_rst_pulses", cnt_min, 2);
    step(1'b1);
    rst = 1'b1;
    step(1'b0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_run_en", int'(run_en), 1);
    chk("rst_inc", int'(inc_min) + int'(inc_hour), 0);
    chk("rst_no_partial", cnt_min, 2);
    rst = 1'b0; btn_up = 1'b0;
    repeat (5) step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
